// File: rtl/pix_clk_ctrl.sv
// ---------------------------------------------------------------------------
// pix_clk_ctrl
//
// Programmable pixel-rate scheduler. Produces a one-cycle tick strobe every
// `div` system clocks plus a phase signal that is high for the first
// floor(div/2) cycles of each period. The divisor can be reprogrammed at run
// time; while running, a new divisor is held pending and only swapped in on a
// period boundary so no period is ever truncated.
//
// Parameters
//   CNT_W      width of divisor / period counter
//   DEF_DIV    divisor loaded at reset (2 <= DEF_DIV < 2**CNT_W)
//
// Ports
//   clk_i       system clock, rising edge
//   rst_        asynchronous active-low reset
//   run_i       level: 1 runs the tick generator, 0 stops it
//   cfg_req_i   one-cycle divisor change request
//   cfg_div_i   requested divisor, sampled with cfg_req_i
//   cfg_ack_o   pulse: new divisor has become active
//   cfg_err_o   pulse: request rejected (divisor < 2 or change already pending)
//   busy_o      a divisor change is pending
//   tick_o      one-cycle strobe per period
//   half_o      phase signal, high in the first half of each period
//   tick_cnt_o  free-running 16-bit tick counter (wraps)
// ---------------------------------------------------------------------------
module pix_clk_ctrl #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 4
) (
   input  logic             clk_i,
   input  logic             rst_,
   input  logic             run_i,
   input  logic             cfg_req_i,
   input  logic [CNT_W-1:0] cfg_div_i,
   output logic             cfg_ack_o,
   output logic             cfg_err_o,
   output logic             busy_o,
   output logic             tick_o,
   output logic             half_o,
   output logic [15:0]      tick_cnt_o
);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO_C     = CNT_W'(2);

   state_t           state_reg;
   logic [CNT_W-1:0] div_reg;
   logic [CNT_W-1:0] pend_div_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic             cfg_legal;
   logic             cfg_bad;
   logic             at_wrap;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] start_div;
   logic             half_run;
   logic             half_start;
   logic             half_swap;

   // busy_o is the registered image of "state is PEND", so it can be used
   // directly to refuse a second request while one is still outstanding.
   assign cfg_legal = cfg_req_i && (cfg_div_i >= TWO_C) && !busy_o;
   assign cfg_bad   = cfg_req_i && !cfg_legal;

   assign at_wrap   = (cnt_reg == div_reg - ONE_C);
   assign cnt_next  = at_wrap ? '0 : cnt_reg + ONE_C;

   // Phase for the counter value about to be loaded.
   assign half_run   = (cnt_next < (div_reg >> 1));
   // Leaving STOP: a request accepted on the same edge governs the first period.
   assign start_div  = cfg_legal ? cfg_div_i : div_reg;
   assign half_start = ('0 < (start_div >> 1));
   // Boundary swap in PEND: counter restarts at 0 under the pending divisor.
   assign half_swap  = ('0 < (pend_div_reg >> 1));

   always_ff @(posedge clk_i or negedge rst_) begin
      if (!rst_) begin
         state_reg    <= ST_STOP;
         div_reg      <= DEF_DIV_C;
         pend_div_reg <= '0;
         cnt_reg      <= '0;
         cfg_ack_o    <= 1'b0;
         cfg_err_o    <= 1'b0;
         busy_o       <= 1'b0;
         tick_o       <= 1'b0;
         half_o       <= 1'b0;
         tick_cnt_o   <= 16'h0000;
      end else begin
         tick_o    <= 1'b0;
         cfg_ack_o <= 1'b0;
         cfg_err_o <= cfg_bad;

         case (state_reg)
            ST_STOP: begin
               cnt_reg <= '0;
               half_o  <= 1'b0;
               if (cfg_legal) begin
                  div_reg   <= cfg_div_i;
                  cfg_ack_o <= 1'b1;
               end
               if (run_i) begin
                  state_reg <= ST_RUN;
                  half_o    <= half_start;
               end
            end

            ST_RUN: begin
               if (!run_i) begin
                  state_reg <= ST_STOP;
                  cnt_reg   <= '0;
                  half_o    <= 1'b0;
                  // Nothing to wait for when stopped: apply immediately.
                  if (cfg_legal) begin
                     div_reg   <= cfg_div_i;
                     cfg_ack_o <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_next;
                  half_o  <= half_run;
                  if (at_wrap) begin
                     tick_o     <= 1'b1;
                     tick_cnt_o <= tick_cnt_o + 16'd1;
                  end
                  // A request on the wrap edge itself waits a full period.
                  if (cfg_legal) begin
                     pend_div_reg <= cfg_div_i;
                     state_reg    <= ST_PEND;
                     busy_o       <= 1'b1;
                  end
               end
            end

            ST_PEND: begin
               if (!run_i) begin
                  state_reg <= ST_STOP;
                  cnt_reg   <= '0;
                  half_o    <= 1'b0;
                  div_reg   <= pend_div_reg;
                  cfg_ack_o <= 1'b1;
                  busy_o    <= 1'b0;
               end else if (at_wrap) begin
                  state_reg  <= ST_RUN;
                  cnt_reg    <= '0;
                  half_o     <= half_swap;
                  div_reg    <= pend_div_reg;
                  tick_o     <= 1'b1;
                  tick_cnt_o <= tick_cnt_o + 16'd1;
                  cfg_ack_o  <= 1'b1;
                  busy_o     <= 1'b0;
               end else begin
                  cnt_reg <= cnt_next;
                  half_o  <= half_run;
               end
            end

            default: begin
               state_reg <= ST_STOP;
               cnt_reg   <= '0;
               half_o    <= 1'b0;
               busy_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pix_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pix_clk_ctrl
//
// Directed bench for pix_clk_ctrl (CNT_W=8, DEF_DIV=4). A period-position
// model tracks the expected outputs every cycle; a negedge compare process
// checks all outputs against it, and the directed sequence adds literal
// expectations for tick spacing, phase pattern, ack/err/busy timing and reset.
// ---------------------------------------------------------------------------
module tb_pix_clk_ctrl;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        run    = 1'b0;
   logic        req    = 1'b0;
   logic [7:0]  div_in = 8'd0;

   logic        cfg_ack;
   logic        cfg_err;
   logic        busy;
   logic        tick;
   logic        half;
   logic [15:0] tick_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   pix_clk_ctrl #(.CNT_W(8), .DEF_DIV(4)) dut (
      .clk_i      (clk),
      .rst_       (rst_n),
      .run_i      (run),
      .cfg_req_i  (req),
      .cfg_div_i  (div_in),
      .cfg_ack_o  (cfg_ack),
      .cfg_err_o  (cfg_err),
      .busy_o     (busy),
      .tick_o     (tick),
      .half_o     (half),
      .tick_cnt_o (tick_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks how many edges have elapsed in the current period (m_pos); a
   // period is complete when that reaches the active divisor.
   bit          m_run;
   int          m_div;
   int          m_pend;
   bit          m_pv;
   int          m_pos;
   logic        e_tick, e_half, e_ack, e_err, e_busy;
   logic [15:0] e_tcnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run  = 1'b0;
         m_div  = 4;
         m_pend = 0;
         m_pv   = 1'b0;
         m_pos  = 0;
         e_tick = 1'b0;
         e_half = 1'b0;
         e_ack  = 1'b0;
         e_err  = 1'b0;
         e_busy = 1'b0;
         e_tcnt = 16'h0000;
      end else begin : model_step
         bit ok;
         ok     = req && (int'(div_in) >= 2) && !m_pv;
         e_err  = req && !ok;
         e_ack  = 1'b0;
         e_tick = 1'b0;
         if (!m_run) begin
            if (ok) begin
               m_div = int'(div_in);
               e_ack = 1'b1;
            end
            if (run) begin
               m_run = 1'b1;
               m_pos = 0;
            end
         end else if (!run) begin
            m_run = 1'b0;
            m_pos = 0;
            if (m_pv) begin
               m_div = m_pend;
               m_pv  = 1'b0;
               e_ack = 1'b1;
            end
            if (ok) begin
               m_div = int'(div_in);
               e_ack = 1'b1;
            end
         end else begin
            m_pos = m_pos + 1;
            if (m_pos == m_div) begin
               m_pos  = 0;
               e_tick = 1'b1;
               e_tcnt = e_tcnt + 16'd1;
               if (m_pv) begin
                  m_div = m_pend;
                  m_pv  = 1'b0;
                  e_ack = 1'b1;
               end
            end
            if (ok) begin
               m_pv   = 1'b1;
               m_pend = int'(div_in);
            end
         end
         e_half = m_run && (m_pos < m_div / 2);
         e_busy = m_pv;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_tick",     32'(tick),     32'(e_tick));
         chk("model_half",     32'(half),     32'(e_half));
         chk("model_ack",      32'(cfg_ack),  32'(e_ack));
         chk("model_err",      32'(cfg_err),  32'(e_err));
         chk("model_busy",     32'(busy),     32'(e_busy));
         chk("model_tick_cnt", 32'(tick_cnt), 32'(e_tcnt));
      end
   end

   // Counts negedges until tick_o is seen high (bounded).
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tick !== 1'b1 && n < 60);
      chk("wait_tick_seen", 32'(tick), 32'd1);
   endtask

   initial begin : stim
      int n;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      @(negedge clk);
      $display("reset: tick=%0b half=%0b ack=%0b err=%0b busy=%0b cnt=%0d", tick, half, cfg_ack, cfg_err, busy, tick_cnt);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_half", 32'(half), 32'd0);
      chk("rst_ack",  32'(cfg_ack), 32'd0);
      chk("rst_err",  32'(cfg_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt",  32'(tick_cnt), 32'd0);

      // Start with default divisor 4: ticks after edges k+4, k+8, k+12.
      run = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         @(negedge clk);
         chk("t1_tick", 32'(tick), 32'((i == 4) || (i == 8) || (i == 12)));
         chk("t1_half", 32'(half), 32'((i % 4) < 2));
      end
      $display("start div4: tick_cnt=%0d after 12 cycles", tick_cnt);
      chk("t1_tick_cnt", 32'(tick_cnt), 32'd3);

      // Request 6 when cnt=1, then a rejected 8 while pending.
      @(negedge clk);
      req = 1'b1; div_in = 8'd6;
      @(negedge clk);
      chk("t2_busy_rise", 32'(busy), 32'd1);
      chk("t2_no_ack", 32'(cfg_ack), 32'd0);
      div_in = 8'd8;
      @(negedge clk);
      req = 1'b0;
      $display("second request while pending: err=%0b busy=%0b", cfg_err, busy);
      chk("t4_err", 32'(cfg_err), 32'd1);
      chk("t4_busy", 32'(busy), 32'd1);
      @(negedge clk);
      $display("boundary: tick=%0b ack=%0b busy=%0b", tick, cfg_ack, busy);
      chk("t2_tick", 32'(tick), 32'd1);
      chk("t2_ack", 32'(cfg_ack), 32'd1);
      chk("t2_busy_clr", 32'(busy), 32'd0);
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         chk("t2_tick6", 32'(tick), 32'((j % 6) == 0));
         chk("t2_half6", 32'(half), 32'((j % 6) < 3));
      end

      // Illegal divisors 1 and 0.
      req = 1'b1; div_in = 8'd1;
      @(negedge clk);
      $display("div=1 request: err=%0b busy=%0b", cfg_err, busy);
      chk("t3_err1", 32'(cfg_err), 32'd1);
      chk("t3_busy1", 32'(busy), 32'd0);
      div_in = 8'd0;
      @(negedge clk);
      req = 1'b0;
      $display("div=0 request: err=%0b busy=%0b", cfg_err, busy);
      chk("t3_err0", 32'(cfg_err), 32'd1);
      chk("t3_busy0", 32'(busy), 32'd0);
      wait_tick(n);
      chk("t3_gap_rest", 32'(n), 32'd4);
      wait_tick(n);
      $display("tick spacing after rejects: %0d", n);
      chk("t3_gap6", 32'(n), 32'd6);

      // Pending 5, then run dropped mid-period.
      req = 1'b1; div_in = 8'd5;
      @(negedge clk);
      req = 1'b0;
      chk("t5_busy", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      $display("stop in pend: tick=%0b half=%0b ack=%0b busy=%0b", tick, half, cfg_ack, busy);
      chk("t5_tick", 32'(tick), 32'd0);
      chk("t5_half", 32'(half), 32'd0);
      chk("t5_ack", 32'(cfg_ack), 32'd1);
      chk("t5_busy_clr", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      run = 1'b1;
      wait_tick(n);
      $display("restart div5: first tick after %0d negedges", n);
      chk("t5_first", 32'(n), 32'd6);
      wait_tick(n);
      chk("t5_gap5", 32'(n), 32'd5);

      // Config in STOP, then config together with run rising.
      run = 1'b0;
      @(negedge clk);
      req = 1'b1; div_in = 8'd7;
      @(negedge clk);
      $display("stop config 7: ack=%0b busy=%0b tick=%0b", cfg_ack, busy, tick);
      chk("t6_ack_stop", 32'(cfg_ack), 32'd1);
      chk("t6_busy_stop", 32'(busy), 32'd0);
      div_in = 8'd3; run = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("t6_ack_start", 32'(cfg_ack), 32'd1);
      chk("t6_half_start", 32'(half), 32'd1);
      wait_tick(n);
      $display("config+run div3: first tick after %0d", n);
      chk("t6_first3", 32'(n), 32'd3);
      wait_tick(n);
      chk("t6_gap3", 32'(n), 32'd3);

      // run falling together with a legal request.
      req = 1'b1; div_in = 8'd2; run = 1'b0;
      @(negedge clk);
      req = 1'b0;
      $display("stop+config 2: ack=%0b tick=%0b half=%0b", cfg_ack, tick, half);
      chk("t7_ack", 32'(cfg_ack), 32'd1);
      chk("t7_tick", 32'(tick), 32'd0);
      chk("t7_half", 32'(half), 32'd0);
      run = 1'b1;
      wait_tick(n);
      chk("t7_first2", 32'(n), 32'd3);
      wait_tick(n);
      chk("t7_gap2", 32'(n), 32'd2);

      // Request sampled on the wrap edge: applies one full old period later.
      @(negedge clk);
      req = 1'b1; div_in = 8'd4;
      @(negedge clk);
      req = 1'b0;
      $display("wrap-edge request: tick=%0b busy=%0b ack=%0b", tick, busy, cfg_ack);
      chk("t8_tick", 32'(tick), 32'd1);
      chk("t8_busy", 32'(busy), 32'd1);
      chk("t8_no_ack", 32'(cfg_ack), 32'd0);
      wait_tick(n);
      chk("t8_old_gap", 32'(n), 32'd2);
      chk("t8_ack", 32'(cfg_ack), 32'd1);
      wait_tick(n);
      chk("t8_gap4", 32'(n), 32'd4);

      // Asynchronous reset while a change is pending.
      req = 1'b1; div_in = 8'd9;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("async reset: tick=%0b half=%0b busy=%0b cnt=%0d", tick, half, busy, tick_cnt);
      chk("ar_tick", 32'(tick), 32'd0);
      chk("ar_half", 32'(half), 32'd0);
      chk("ar_ack",  32'(cfg_ack), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_cnt",  32'(tick_cnt), 32'd0);
      run = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("ar_idle_tick", 32'(tick), 32'd0);
      chk("ar_idle_half", 32'(half), 32'd0);
      run = 1'b1;
      wait_tick(n);
      $display("after reset: first tick after %0d (default div)", n);
      chk("ar_first4", 32'(n), 32'd5);
      wait_tick(n);
      chk("ar_gap4", 32'(n), 32'd4);
      chk("ar_tick_cnt", 32'(tick_cnt), 32'd2);

      repeat (4) @(negedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
